bist_controller: RTL and testbench

Sequencer and checker at the consuming end of the multiplier self-test path.
- On start: clears the pattern generator (LFSR) and the signature analyzer, then enables both for a programmed number of patterns.
- Enables the analyzer alone for a fixed number of extra cycles to drain the multiplier pipeline.
- Captures the final signature, compares it with a golden value and reports pass/fail.
- Sits beside the multiplier test block and drives its enables and clears.

---
 rtl/bist_controller_if.sv | 41 ++++
 rtl/bist_controller.sv | 130 +++++++++++++
 tb/tb_bist_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bist_controller_if.sv
// Control/result bundle between the BIST sequencer and its host plus the multiplier test path.
// Optional BIST_SIG_CAPTURE_EN adds the captured-signature and diff result fields.
interface bist_controller_if #(
  parameter int SIG_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_patterns;
  logic [SIG_W-1:0] golden;
  logic [SIG_W-1:0] signature;
  logic             gen_clr;
  logic             sa_clr;
  logic             gen_en;
  logic             sa_en;
  logic             busy;
  logic             done;
  logic             pass;
`ifdef BIST_SIG_CAPTURE_EN
  logic [SIG_W-1:0] sig_captured;
  logic [SIG_W-1:0] sig_diff;
`endif

  // Host / test-path side: issues requests, supplies the live signature.
  modport master (
    output start, abort, num_patterns, golden, signature,
    input  gen_clr, sa_clr, gen_en, sa_en, busy, done, pass
`ifdef BIST_SIG_CAPTURE_EN
    , input sig_captured, sig_diff
`endif
  );

  // Controller side.
  modport slave (
    input  start, abort, num_patterns, golden, signature,
    output gen_clr, sa_clr, gen_en, sa_en, busy, done, pass
`ifdef BIST_SIG_CAPTURE_EN
    , output sig_captured, sig_diff
`endif
  );
endinterface

// File: rtl/bist_controller.sv
// BIST sequencer: clear, run num_patterns, flush FLUSH_CYCLES, check signature; busy 1+N+FLUSH+1 cycles, done 1 later.
// Optional BIST_SIG_CAPTURE_EN adds sig_captured/sig_diff diagnostics; start while busy is ignored, abort wins everywhere.
module bist_controller #(
  parameter int SIG_W        = 16,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_b,
  bist_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    CHECK = 3'd4
  } state_t;

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] np_lat;
  logic [CNT_W-1:0] cnt;
  logic [SIG_W-1:0] golden_lat;
  logic [3:0]       flush_cnt;

  // Outputs are assigned for the state being entered, so they always track the current state.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state        <= IDLE;
      np_lat       <= '0;
      cnt          <= '0;
      golden_lat   <= '0;
      flush_cnt    <= '0;
      bus.gen_clr  <= 1'b0;
      bus.sa_clr   <= 1'b0;
      bus.gen_en   <= 1'b0;
      bus.sa_en    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.pass     <= 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
      bus.sig_captured <= '0;
      bus.sig_diff     <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state       <= IDLE;
        bus.gen_clr <= 1'b0;
        bus.sa_clr  <= 1'b0;
        bus.gen_en  <= 1'b0;
        bus.sa_en   <= 1'b0;
        bus.busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state       <= CLEAR;
              np_lat      <= bus.num_patterns;
              golden_lat  <= bus.golden;
              bus.pass    <= 1'b0;
              bus.gen_clr <= 1'b1;
              bus.sa_clr  <= 1'b1;
              bus.busy    <= 1'b1;
`ifdef BIST_SIG_CAPTURE_EN
              bus.sig_captured <= '0;
              bus.sig_diff     <= '0;
`endif
            end
          end

          CLEAR: begin
            cnt         <= np_lat;
            bus.gen_clr <= 1'b0;
            bus.sa_clr  <= 1'b0;
            if (np_lat != '0) begin
              state      <= RUN;
              bus.gen_en <= 1'b1;
              bus.sa_en  <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end

          RUN: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state      <= FLUSH;
              flush_cnt  <= FLUSH_LD;
              bus.gen_en <= 1'b0;
            end
          end

          // Analyzer keeps absorbing results still in flight through the multiplier.
          FLUSH: begin
            flush_cnt <= flush_cnt - 4'd1;
            if (flush_cnt == 4'd1) begin
              state     <= CHECK;
              bus.sa_en <= 1'b0;
            end
          end

          CHECK: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (bus.signature == golden_lat);
`ifdef BIST_SIG_CAPTURE_EN
            bus.sig_captured <= bus.signature;
            bus.sig_diff     <= bus.signature ^ golden_lat;
`endif
          end

          default: begin
            state       <= IDLE;
            bus.gen_clr <= 1'b0;
            bus.sa_clr  <= 1'b0;
            bus.gen_en  <= 1'b0;
            bus.sa_en   <= 1'b0;
            bus.busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller with a simple additive signature analyzer in the environment.
module tb_bist_controller;
  localparam int SIG_W = 16;
  localparam int CNT_W = 16;
  localparam int FLUSH = 2;

  logic clk;
  logic reset_b;
  int   total = 0;
  int   bad   = 0;

  bist_controller_if #(.SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();

  bist_controller #(.SIG_W(SIG_W), .CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Analyzer stand-in: seed 5A5A on clear, +1 per sa_en cycle, +0x100 more per gen_en cycle.
  logic [SIG_W-1:0] sig_model;
  always @(posedge clk or negedge reset_b) begin
    if (!reset_b)        sig_model <= '0;
    else if (bus.sa_clr) sig_model <= 16'h5A5A;
    else if (bus.sa_en)  sig_model <= sig_model + 16'h0001 + (bus.gen_en ? 16'h0100 : 16'h0000);
  end
  assign bus.signature = sig_model;

  typedef struct {
    logic [15:0] n;
    logic [15:0] g;
    logic        p;
    int          gen;
    int          sa;
    int          bsy;
    logic [15:0] diff;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int outs();
    return {25'd0, bus.gen_clr, bus.sa_clr, bus.gen_en, bus.sa_en, bus.busy, bus.done, bus.pass};
  endfunction

  task automatic run_test(input string nm, input vec_t v, input int poke);
    int gc, sac, gec, sec, bc, dc;
    logic pass_at_done;
    logic [15:0] diff_at_done;
    gc = 0; sac = 0; gec = 0; sec = 0; bc = 0; dc = 0;
    pass_at_done = 1'b0;
    diff_at_done = '0;
    @(negedge clk);
    bus.num_patterns = v.n;
    bus.golden       = v.g;
    bus.start        = 1'b1;
    for (int i = 0; i < int'(v.n) + FLUSH + 8; i++) begin
      @(negedge clk);
      gc  += int'(bus.gen_clr);
      sac += int'(bus.sa_clr);
      gec += int'(bus.gen_en);
      sec += int'(bus.sa_en);
      bc  += int'(bus.busy);
      if (bus.done) begin
        dc++;
        pass_at_done = bus.pass;
`ifdef BIST_SIG_CAPTURE_EN
        diff_at_done = bus.sig_diff;
`endif
      end
      if (i == 0) bus.start = 1'b0;
      if (i == poke) begin
        bus.start = 1'b1; bus.num_patterns = 16'd3; bus.golden = 16'h0000;
      end else if (i == poke + 1) begin
        bus.start = 1'b0; bus.num_patterns = v.n; bus.golden = v.g;
      end
    end
    chk({nm, " gen_clr"}, gc, 1);
    chk({nm, " sa_clr"}, sac, 1);
    chk({nm, " gen_en"}, gec, v.gen);
    chk({nm, " sa_en"}, sec, v.sa);
    chk({nm, " busy"}, bc, v.bsy);
    chk({nm, " done"}, dc, 1);
    chk({nm, " pass@done"}, int'(pass_at_done), int'(v.p));
    chk({nm, " pass held"}, int'(bus.pass), int'(v.p));
`ifdef BIST_SIG_CAPTURE_EN
    chk({nm, " sig_diff"}, int'(diff_at_done), int'(v.diff));
`else
    if (diff_at_done != '0) chk({nm, " diff"}, int'(diff_at_done), 0);
`endif
  endtask

  initial begin
    int run_cnt, dc;
    logic found;
    vt[0] = '{16'd10, 16'h6466, 1'b1, 10, 12, 14, 16'h0000};
    vt[1] = '{16'd10, 16'h6467, 1'b0, 10, 12, 14, 16'h0001};
    vt[2] = '{16'd0,  16'h5A5A, 1'b1, 0,  0,  2,  16'h0000};
    vt[3] = '{16'd0,  16'h0000, 1'b0, 0,  0,  2,  16'h5A5A};
    vt[4] = '{16'd1,  16'h5B5D, 1'b1, 1,  3,  5,  16'h0000};
    vt[5] = '{16'd3,  16'h5D5F, 1'b1, 3,  5,  7,  16'h0000};

    // Reset held with start asserted.
    reset_b = 1'b0;
    bus.start = 1'b1; bus.abort = 1'b0;
    bus.num_patterns = 16'd5; bus.golden = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset outs", outs(), 0);
    bus.start = 1'b0;
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("post reset idle", outs(), 0);

    for (int k = 0; k < 6; k++) run_test($sformatf("vec%0d", k), vt[k], -1);

    // Start during RUN is ignored.
    run_test("start in run", vt[0], 4);

    // abort and start together in IDLE.
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort over start", int'(bus.busy), 0);
    @(negedge clk);
    chk("abort over start 2", int'(bus.busy), 0);

    // Abort on the 5th RUN cycle of a 100-pattern test.
    bus.num_patterns = 16'd100; bus.golden = 16'h0000; bus.start = 1'b1;
    run_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.gen_en) run_cnt++;
      if (run_cnt == 5) begin
        bus.abort = 1'b1;
        break;
      end
    end
    chk("abort reached run5", run_cnt, 5);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort outs", outs(), 0);
    dc = 0;
    repeat (5) begin
      @(negedge clk);
      dc += int'(bus.done);
    end
    chk("abort no done", dc, 0);
    chk("abort pass", int'(bus.pass), 0);
    run_test("after abort", vt[0], -1);

    // Reset pulsed during FLUSH.
    @(negedge clk);
    bus.num_patterns = 16'd4; bus.golden = 16'h0000; bus.start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (!bus.gen_en && bus.sa_en) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached flush", int'(found), 1);
    #2 reset_b = 1'b0;
    #1 chk("reset in flush", outs(), 0);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    chk("idle after reset", outs(), 0);

    // Start in the same cycle as the done pulse.
    @(negedge clk);
    bus.num_patterns = 16'd2; bus.golden = 16'h5C5E; bus.start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        found = 1'b1;
        chk("b2b pass at done", int'(bus.pass), 1);
        bus.start = 1'b1; bus.num_patterns = 16'd0; bus.golden = 16'h5A5A;
        break;
      end
    end
    chk("b2b done seen", int'(found), 1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b pass cleared", int'(bus.pass), 0);
    chk("b2b busy", int'(bus.busy), 1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1'b1;
        chk("b2b second pass", int'(bus.pass), 1);
        break;
      end
    end
    chk("b2b second done", int'(found), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
